// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field map, opcodes, default widths and fetch FSM states.
package cpu_pkg;

  localparam int unsigned DEF_PC_W    = 32;
  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned OPC_W       = 5;

  // Instruction field map
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 11;
  localparam int unsigned RDST_MSB = 10;
  localparam int unsigned RDST_LSB = 8;
  localparam int unsigned RS1_MSB  = 7;
  localparam int unsigned RS1_LSB  = 5;
  localparam int unsigned RS2_MSB  = 4;
  localparam int unsigned RS2_LSB  = 2;

  localparam logic [OPC_W-1:0] OP_NOP = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDM = 5'b00001;

  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_WORD = 16'h0000;

  typedef enum logic [0:0] {
    S_FETCH,
    S_IMM
  } fetchState_e;

  function automatic logic [OPC_W-1:0] getOpcode(input logic [DEF_INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and instruction memory (slave).
interface fetch_stage_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 16
);
  logic [PC_W-1:0]    imemAddr;
  logic [INSTR_W-1:0] imemData;

  modport master (output imemAddr, input imemData);
  modport slave  (input imemAddr, output imemData);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: synchronous clear (reset or bubble) takes priority over load.
module ifid_reg #(
  parameter int unsigned        PC_W     = 32,
  parameter int unsigned        INSTR_W  = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ld,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [INSTR_W-1:0] immIn,
  input  logic [PC_W-1:0]    pcIn,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] imm,
  output logic [PC_W-1:0]    pc,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (clr) begin
      instr <= NOP_WORD;
      imm   <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (ld) begin
      instr <= instrIn;
      imm   <= immIn;
      pc    <= pcIn;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; assembles two-word LDM (opcode word + immediate).
// Build option: define FETCH_COUNT_EN to implement the retired-fetch counter on fetchCount.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned        PC_W       = DEF_PC_W,
  parameter int unsigned        INSTR_W    = DEF_INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC   = '0,
  parameter logic [OPC_W-1:0]   LDM_OPCODE = OP_LDM,
  parameter logic [INSTR_W-1:0] NOP_WORD   = DEF_NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirectPc,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic [INSTR_W-1:0] ifidImm,
  output logic [PC_W-1:0]    ifidPc,
  output logic               ifidValid,
  output logic [OPC_W-1:0]   opCode,
  output logic               ldmEn,
  output logic [31:0]        fetchCount
);

  fetchState_e        stateQ, stateD;
  logic [PC_W-1:0]    pcQ, pcD;
  logic [INSTR_W-1:0] holdQ, holdD;
  logic [PC_W-1:0]    holdPcQ, holdPcD;

  logic               loadValid;
  logic               bubble;
  logic [INSTR_W-1:0] instrIn;
  logic [INSTR_W-1:0] immIn;
  logic [PC_W-1:0]    pcIn;
  logic [PC_W-1:0]    pcInc;

  assign imem.imemAddr = pcQ;
  assign pcInc         = pcQ + PC_W'(1);

  always_comb begin
    stateD    = stateQ;
    pcD       = pcQ;
    holdD     = holdQ;
    holdPcD   = holdPcQ;
    loadValid = 1'b0;
    bubble    = 1'b0;
    instrIn   = imem.imemData;
    immIn     = '0;
    pcIn      = pcQ;

    if (redirect) begin
      // Redirect beats stall and abandons any half-assembled LDM.
      pcD     = redirectPc;
      stateD  = S_FETCH;
      holdD   = '0;
      holdPcD = '0;
      bubble  = 1'b1;
    end else if (!stall) begin
      pcD = pcInc;
      unique case (stateQ)
        S_FETCH: begin
          if (imem.imemData[OPC_MSB:OPC_LSB] == LDM_OPCODE) begin
            holdD   = imem.imemData;
            holdPcD = pcQ;
            bubble  = 1'b1;
            stateD  = S_IMM;
          end else begin
            loadValid = 1'b1;
          end
        end
        S_IMM: begin
          instrIn   = holdQ;
          immIn     = imem.imemData;
          pcIn      = holdPcQ;
          loadValid = 1'b1;
          stateD    = S_FETCH;
        end
        default: stateD = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= S_FETCH;
      pcQ     <= RESET_PC;
      holdQ   <= '0;
      holdPcQ <= '0;
    end else begin
      stateQ  <= stateD;
      pcQ     <= pcD;
      holdQ   <= holdD;
      holdPcQ <= holdPcD;
    end
  end

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .NOP_WORD(NOP_WORD)
  ) u_ifid (
    .clk    (clk),
    .clr    (rst | bubble),
    .ld     (loadValid),
    .instrIn(instrIn),
    .immIn  (immIn),
    .pcIn   (pcIn),
    .instr  (ifidInstr),
    .imm    (ifidImm),
    .pc     (ifidPc),
    .valid  (ifidValid)
  );

  assign opCode = ifidInstr[OPC_MSB:OPC_LSB];
  assign ldmEn  = ifidValid & (opCode == LDM_OPCODE);

`ifdef FETCH_COUNT_EN
  logic [31:0] countQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      countQ <= '0;
    end else if (loadValid) begin
      countQ <= countQ + 32'd1;
    end
  end

  assign fetchCount = countQ;
`else
  assign fetchCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, straight-line, LDM, stall, redirect, wrap, reset mid-LDM.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [15:0] ifidInstr;
  logic [15:0] ifidImm;
  logic [31:0] ifidPc;
  logic        ifidValid;
  logic [4:0]  opCode;
  logic        ldmEn;
  logic [31:0] fetchCount;

  logic [15:0] mem [128];
  int unsigned nCompared;
  int unsigned nMismatched;
  int unsigned expCount;

  fetch_stage_if #(.PC_W(32), .INSTR_W(16)) imemBus ();

  assign imemBus.imemData = mem[imemBus.imemAddr[6:0]];

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .redirect  (redirect),
    .redirectPc(redirectPc),
    .imem      (imemBus.master),
    .ifidInstr (ifidInstr),
    .ifidImm   (ifidImm),
    .ifidPc    (ifidPc),
    .ifidValid (ifidValid),
    .opCode    (opCode),
    .ldmEn     (ldmEn),
    .fetchCount(fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cntExp();
`ifdef FETCH_COUNT_EN
    return expCount;
`else
    return 32'd0;
`endif
  endfunction

  task automatic checkIfid(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                           input logic [31:0] pc, input logic valid, input logic ldm,
                           input logic [31:0] addr);
    check({tag, ".instr"}, 32'(ifidInstr), 32'(instr));
    check({tag, ".imm"}, 32'(ifidImm), 32'(imm));
    check({tag, ".pc"}, ifidPc, pc);
    check({tag, ".valid"}, 32'(ifidValid), 32'(valid));
    check({tag, ".opCode"}, 32'(opCode), 32'(instr[15:11]));
    check({tag, ".ldmEn"}, 32'(ldmEn), 32'(ldm));
    check({tag, ".addr"}, imemBus.imemAddr, addr);
    check({tag, ".count"}, fetchCount, cntExp());
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    expCount    = 0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[0]    = 16'h2100;
    mem[1]    = 16'h2200;
    mem[2]    = 16'h3300;
    mem[3]    = 16'h4400;
    mem[4]    = 16'h0900;
    mem[5]    = 16'hBEEF;
    mem[6]    = 16'h5500;
    mem[7]    = 16'h0A00;
    mem[8]    = 16'h1234;
    mem[64]   = 16'h6600;
    mem[127]  = 16'h0B00;

    rst        = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = 32'h0;

    // Reset held two cycles
    step();
    checkIfid("rst1", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkIfid("rst2", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // Straight-line fetch
    step(); expCount++;
    checkIfid("seq0", 16'h2100, 16'h0000, 32'h0, 1'b1, 1'b0, 32'h1);
    step(); expCount++;
    checkIfid("seq1", 16'h2200, 16'h0000, 32'h1, 1'b1, 1'b0, 32'h2);
    step(); expCount++;
    checkIfid("seq2", 16'h3300, 16'h0000, 32'h2, 1'b1, 1'b0, 32'h3);
    step(); expCount++;
    checkIfid("seq3", 16'h4400, 16'h0000, 32'h3, 1'b1, 1'b0, 32'h4);

    // LDM at 4/5
    step();
    checkIfid("ldmBub", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h5);
    step(); expCount++;
    checkIfid("ldm", 16'h0900, 16'hBEEF, 32'h4, 1'b1, 1'b1, 32'h6);
    step(); expCount++;
    checkIfid("seq6", 16'h5500, 16'h0000, 32'h6, 1'b1, 1'b0, 32'h7);

    // Stall three cycles with PC=7
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkIfid("stall", 16'h5500, 16'h0000, 32'h6, 1'b1, 1'b0, 32'h7);
    end
    stall = 1'b0;

    // LDM at 7, redirected away while waiting for its immediate
    step();
    checkIfid("ldm7Bub", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h8);
    redirect   = 1'b1;
    redirectPc = 32'h40;
    step();
    checkIfid("redir", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h40);
    redirect = 1'b0;
    step(); expCount++;
    checkIfid("tgt40", 16'h6600, 16'h0000, 32'h40, 1'b1, 1'b0, 32'h41);

    // Redirect wins over a simultaneous stall; LDM at last address wraps to 0
    stall      = 1'b1;
    redirect   = 1'b1;
    redirectPc = 32'hFFFF_FFFF;
    step();
    checkIfid("redirStall", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    stall    = 1'b0;
    redirect = 1'b0;
    step();
    checkIfid("wrapBub", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h0);
    step(); expCount++;
    checkIfid("wrapLdm", 16'h0B00, 16'h2100, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h1);

    // Reset during S_IMM: no partial LDM afterwards
    redirect   = 1'b1;
    redirectPc = 32'h4;
    step();
    redirect = 1'b0;
    step();
    checkIfid("ldm4Bub", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h5);
    rst = 1'b1;
    step(); expCount = 0;
    checkIfid("rstImm", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step(); expCount++;
    checkIfid("postRst", 16'h2100, 16'h0000, 32'h0, 1'b1, 1'b0, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of controlUnit.
- Drives the PC into instruction memory and assembles two-word LDM instructions (opcode word + 16-bit immediate).
- Presents opcode, register fields and immediate to decode.
- Drives ldmEn, which feeds controlUnit's enable input, so ldm asserts only when the immediate is already in the IF/ID register.

Parameters:
- PC_W, 32, program counter / imem address width
- INSTR_W, 16, instruction word width
- RESET_PC, 0, PC value loaded on reset
- LDM_OPCODE, 5'b00001, opcode of the two-word load-immediate instruction
- NOP_WORD, 16'h0000, word inserted as a bubble

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold PC, state and IF/ID contents
- redirect  in  1  load PC from redirectPc and flush the stage
- redirectPc  in  PC_W  redirect target
- imemAddr  out  PC_W  instruction memory address (= PC)
- imemData  in  INSTR_W  combinational read data for imemAddr
- ifidInstr  out  INSTR_W  registered instruction word
- ifidImm  out  INSTR_W  registered immediate (0 unless LDM)
- ifidPc  out  PC_W  address of the registered instruction's first word
- ifidValid  out  1  IF/ID holds a real instruction
- opCode  out  5  ifidInstr[15:11], feeds controlUnit.opCode
- ldmEn  out  1  ifidValid & (opCode == LDM_OPCODE); feeds controlUnit.enable
- fetchCount  out  32  retired-fetch counter (see Optional Feature)

Behaviour:
- Field map: [15:11] opcode, [10:8] rdst, [7:5] rsrc1, [4:2] rsrc2, [1:0] unused.
- States:
  - S_FETCH: first or only word.
  - S_IMM: immediate word of an LDM.
- Reset: PC=RESET_PC, state=S_FETCH, ifidInstr=NOP_WORD, ifidImm=0, ifidPc=0, ifidValid=0, held word=0, fetchCount=0. opCode=0 and ldmEn=0 follow combinationally.
- Priority each cycle: rst > redirect > stall > normal.
- S_FETCH, non-LDM opcode:
  - IF/ID <= {imemData, imm=0, PC, valid=1}; PC <= PC+1; stay in S_FETCH.
  - Throughput 1 instr/cycle; latency 1 cycle from imemAddr to ifid outputs.
- S_FETCH, imemData[15:11]==LDM_OPCODE:
  - Holding reg <= imemData; holdPc <= PC; PC <= PC+1.
  - IF/ID <= bubble (NOP_WORD, valid=0); next state S_IMM.
- S_IMM:
  - IF/ID <= {held word, imm=imemData, holdPc, valid=1}; PC <= PC+1; next state S_FETCH.
  - imemData is not decoded as an opcode in this state.
- stall=1: PC, state, holding reg and all IF/ID outputs unchanged; imemAddr remains the current PC.
- redirect=1: PC <= redirectPc; state <= S_FETCH; holding reg discarded; IF/ID <= bubble. Overrides stall in the same cycle. Redirect during S_IMM abandons the partial LDM.
- PC increment wraps modulo 2^PC_W; no error flag.
- LDM at the last address: immediate is fetched from address 0 after the wrap.
- rst during S_IMM: full reset; no partial LDM is ever presented.
- ldmEn is high only in cycles where ifidValid=1 and the IF/ID holds a complete LDM.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: fetchCount increments by 1 on each cycle IF/ID loads valid=1. Not incremented for stall, bubble or redirect cycles; wraps at 2^32; cleared by rst.
- Undefined: no counter register; fetchCount tied to 32'd0.

Decomposition:
- Shared package (cpu_pkg): opcode constants (LDM_OPCODE, NOP opcode, STD, etc. matching controlUnit decoding), field bit positions, INSTR_W, PC_W, NOP_WORD, fetch state enum {S_FETCH, S_IMM}.
- One natural sub-module: ifid_reg, the IF/ID pipeline register with enable (stall) and synchronous clear (rst | bubble).
- PC and FSM stay in fetch_stage.

Test Plan:
- Reset: rst high 2 cycles with imemData=16'h2100, then low → while rst is high, ifidValid=0, imemAddr=0. First post-reset edge gives ifidInstr=16'h2100, ifidPc=0, ifidValid=1, imemAddr=1.
- Straight-line: imem[0..3]=non-LDM words → one valid IF/ID per cycle, ifidPc=0,1,2,3, ldmEn=0 throughout.
- LDM: imem[4]=16'h0900 (opcode 00001, rdst=1), imem[5]=16'hBEEF → cycle after addr 4: ifidValid=0. Next cycle: ifidInstr=16'h0900, ifidImm=16'hBEEF, ifidPc=4, ldmEn=1. Then imemAddr=6.
- Stall: stall=1 for 3 cycles mid-stream with PC=7 → imemAddr stays 7, IF/ID unchanged. Fetch resumes at 7 after release.
- Redirect mid-LDM: redirect=1, redirectPc=32'h40 in S_IMM → IF/ID bubble, ldmEn=0, imemAddr=32'h40. No LDM ever presented with a wrong immediate.
- With FETCH_COUNT_EN: 5 normal + 1 LDM + 2 stall cycles → fetchCount=6. Without the macro, fetchCount=0.
